// File: rtl/pipemem_ctrl.sv
// rtl/pipemem_ctrl.sv - MEM-stage controller: req/ack data-memory port, stall and bubble insertion
module pipemem_ctrl #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] mAlu,
  input  logic [31:0] mb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mwreg_o,
  output logic [31:0] mmo,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last BUSY count value before the access is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mmo_q, mmo_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  // Remembers whether the in-flight access is a load, so write-back data and
  // the fault substitution only touch mmo for loads.
  logic        load_q, load_d;
  // Set when a load was abandoned on timeout; suppresses write-back in DONE.
  logic        tofault_q, tofault_d;

  logic access;
  logic misalign;

  assign access   = mm2reg | mwmem;
  assign misalign = access & (mAlu[1:0] != 2'b00);

  assign mmo        = mmo_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign mem_err    = err_q;

  // State register and all registered datapath outputs, asynchronously cleared.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      mmo_q     <= 32'h0;
      err_q     <= 1'b0;
      cnt_q     <= 8'h0;
      load_q    <= 1'b0;
      tofault_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mmo_q     <= mmo_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      load_q    <= load_d;
      tofault_q <= tofault_d;
    end
  end

  // Next-state and next-register values; memory port fields stay stable while BUSY.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mmo_d     = mmo_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    load_d    = load_q;
    tofault_d = tofault_q;

    unique case (state_q)
      IDLE: begin
        if (misalign) begin
          // Fault without touching memory; the pipeline keeps moving.
          err_d = 1'b1;
          if (mm2reg) begin
            mmo_d = ERR_DATA;
          end
        end else if (access) begin
          // Load+store together is treated as a load.
          state_d   = BUSY;
          req_d     = 1'b1;
          we_d      = mwmem & ~mm2reg;
          addr_d    = {mAlu[31:2], 2'b00};
          wdata_d   = mb;
          cnt_d     = 8'h0;
          load_d    = mm2reg;
          tofault_d = 1'b0;
        end
      end

      BUSY: begin
        if (dmem_ack) begin
          // An ack on the final count still completes normally.
          req_d   = 1'b0;
          state_d = DONE;
          if (load_q) begin
            mmo_d = dmem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          req_d     = 1'b0;
          err_d     = 1'b1;
          state_d   = DONE;
          tofault_d = load_q;
          if (load_q) begin
            mmo_d = ERR_DATA;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      DONE: begin
        // The pipeline advances on this edge, so IDLE always sees a new instruction.
        state_d   = IDLE;
        tofault_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Stall and MEM/WB write-enable; every stall cycle is a bubble.
  always_comb begin
    stall   = 1'b0;
    mwreg_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (misalign) begin
          stall   = 1'b0;
          mwreg_o = 1'b0;
        end else if (access) begin
          stall   = 1'b1;
          mwreg_o = 1'b0;
        end else begin
          mwreg_o = mwreg;
        end
      end
      BUSY: begin
        stall   = 1'b1;
        mwreg_o = 1'b0;
      end
      DONE: begin
        stall   = 1'b0;
        mwreg_o = mwreg & ~tofault_q;
      end
      default: begin
        stall   = 1'b0;
        mwreg_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pipemem_ctrl.sv
// tb/tb_pipemem_ctrl.sv - directed self-checking bench for pipemem_ctrl
module tb_pipemem_ctrl;

  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clock = 1'b0;
  logic        resetn;
  logic        mwreg, mm2reg, mwmem;
  logic [31:0] mAlu, mb, dmem_rdata;
  logic        dmem_ack;
  logic        mwreg_o, stall, dmem_req, dmem_we, mem_err;
  logic [31:0] mmo, dmem_addr, dmem_wdata;

  int errors = 0;
  int checks = 0;

  pipemem_ctrl #(.TIMEOUT(4), .ERR_DATA(ERR)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .mwreg      (mwreg),
    .mm2reg     (mm2reg),
    .mwmem      (mwmem),
    .mAlu       (mAlu),
    .mb         (mb),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .mwreg_o    (mwreg_o),
    .mmo        (mmo),
    .stall      (stall),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .mem_err    (mem_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic wreg, input logic m2r, input logic wmem,
                        input logic [31:0] alu, input logic [31:0] b);
    mwreg  = wreg;
    mm2reg = m2r;
    mwmem  = wmem;
    mAlu   = alu;
    mb     = b;
    #1;
  endtask

  initial begin
    resetn     = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #10;
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_we", dmem_we, 1'b0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_mmo", mmo, 32'h0);
    chk("rst_err", mem_err, 1'b0);
    chk("rst_stall", stall, 1'b0);
    resetn = 1'b1;

    // ALU op passthrough
    tick();
    set_in(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    chk("alu_stall", stall, 1'b0);
    chk("alu_wreg", mwreg_o, 1'b1);
    tick();
    chk("alu_req", dmem_req, 1'b0);
    chk("alu_mmo", mmo, 32'h0);

    // Load, ack in first BUSY cycle
    set_in(1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    chk("ld_idle_stall", stall, 1'b1);
    chk("ld_idle_wreg", mwreg_o, 1'b0);
    tick();
    chk("ld_busy_req", dmem_req, 1'b1);
    chk("ld_busy_we", dmem_we, 1'b0);
    chk("ld_busy_addr", dmem_addr, 32'h100);
    chk("ld_busy_stall", stall, 1'b1);
    chk("ld_busy_wreg", mwreg_o, 1'b0);
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #1;
    chk("ld_done_mmo", mmo, 32'h1234_5678);
    chk("ld_done_req", dmem_req, 1'b0);
    chk("ld_done_stall", stall, 1'b0);
    chk("ld_done_wreg", mwreg_o, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("ld_after_stall", stall, 1'b0);
    chk("ld_after_req", dmem_req, 1'b0);

    // Store, ack on 4th BUSY cycle (also the timeout cycle: ack wins)
    set_in(1'b0, 1'b0, 1'b1, 32'h204, 32'hCAFE_F00D);
    chk("st_idle_stall", stall, 1'b1);
    chk("st_idle_wreg", mwreg_o, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) dmem_ack = 1'b1;
      chk($sformatf("st_busy%0d_req", i), dmem_req, 1'b1);
      chk($sformatf("st_busy%0d_we", i), dmem_we, 1'b1);
      chk($sformatf("st_busy%0d_addr", i), dmem_addr, 32'h204);
      chk($sformatf("st_busy%0d_wdata", i), dmem_wdata, 32'hCAFE_F00D);
      chk($sformatf("st_busy%0d_stall", i), stall, 1'b1);
      chk($sformatf("st_busy%0d_wreg", i), mwreg_o, 1'b0);
    end
    tick();
    dmem_ack = 1'b0;
    #1;
    chk("st_done_req", dmem_req, 1'b0);
    chk("st_done_err", mem_err, 1'b0);
    chk("st_done_mmo", mmo, 32'h1234_5678);
    chk("st_done_stall", stall, 1'b0);
    chk("st_done_wreg", mwreg_o, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Load timeout (TIMEOUT=4), no ack
    set_in(1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
    chk("to_idle_stall", stall, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("to_busy%0d_req", i), dmem_req, 1'b1);
      chk($sformatf("to_busy%0d_err", i), mem_err, 1'b0);
    end
    tick();
    chk("to_done_req", dmem_req, 1'b0);
    chk("to_done_err", mem_err, 1'b1);
    chk("to_done_mmo", mmo, ERR);
    chk("to_done_stall", stall, 1'b0);
    chk("to_done_wreg", mwreg_o, 1'b0);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("to_idle_err", mem_err, 1'b0);
    chk("to_idle_req", dmem_req, 1'b0);
    chk("to_idle_wreg", mwreg_o, 1'b1);

    // Load with immediate ack to refresh mmo
    set_in(1'b1, 1'b1, 1'b0, 32'h308, 32'h0);
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'hA5A5_5A5A;
    tick();
    dmem_ack = 1'b0;
    #1;
    chk("ld2_mmo", mmo, 32'hA5A5_5A5A);
    chk("ld2_wreg", mwreg_o, 1'b1);
    tick();

    // Misaligned load
    set_in(1'b1, 1'b1, 1'b0, 32'h103, 32'h0);
    chk("mis_stall", stall, 1'b0);
    chk("mis_wreg", mwreg_o, 1'b0);
    chk("mis_req0", dmem_req, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("mis_err", mem_err, 1'b1);
    chk("mis_mmo", mmo, ERR);
    chk("mis_req1", dmem_req, 1'b0);
    tick();
    chk("mis_err_clr", mem_err, 1'b0);

    // Reset during BUSY, late ack ignored, clean restart
    set_in(1'b1, 1'b1, 1'b0, 32'h400, 32'h0);
    tick();
    chk("rb_req", dmem_req, 1'b1);
    resetn = 1'b0;
    #1;
    chk("rb_async_req", dmem_req, 1'b0);
    chk("rb_async_addr", dmem_addr, 32'h0);
    chk("rb_async_mmo", mmo, 32'h0);
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    resetn = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_0000;
    tick();
    dmem_ack = 1'b0;
    #1;
    chk("rb_ack_req", dmem_req, 1'b0);
    chk("rb_ack_mmo", mmo, 32'h0);
    chk("rb_ack_stall", stall, 1'b0);
    set_in(1'b1, 1'b1, 1'b0, 32'h500, 32'h0);
    chk("rb_ld_stall", stall, 1'b1);
    tick();
    chk("rb_ld_req", dmem_req, 1'b1);
    chk("rb_ld_addr", dmem_addr, 32'h500);
    dmem_ack = 1'b1; dmem_rdata = 32'h600D_F00D;
    tick();
    dmem_ack = 1'b0;
    #1;
    chk("rb_ld_mmo", mmo, 32'h600D_F00D);
    chk("rb_ld_wreg", mwreg_o, 1'b1);
    chk("rb_ld_done_req", dmem_req, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
